// File: rtl/idli_uart_tx_m.sv
// Debug/console UART transmitter: pairs execute-unit nibbles into bytes,
// buffers them in a small FIFO and sends them as 8N1 frames at BAUD_DIV clocks per bit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | line high, waiting for a byte in the FIFO
// START   | start bit (line low) for BAUD_DIV cycles
// DATA    | eight data bits, LSB first, BAUD_DIV cycles each
// STOP    | stop bit (line high); chains straight into START if more data
module idli_uart_tx_m #(
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_DIV   = 16
) (
    input  logic       i_utx_gck,
    input  logic       i_utx_rst_n,
    input  logic [3:0] i_utx_data,
    input  logic       i_utx_vld,
    input  logic [1:0] i_utx_ctr,
    input  logic       i_utx_ovf_clr,
    output logic       o_utx_tx,
    output logic       o_utx_busy,
    output logic       o_utx_ovf
);

    localparam int AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW          = AW + 1;
    localparam int BW          = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BAUD_LAST_I = BAUD_DIV - 1;

    localparam logic [CW-1:0] FULL_CNT  = FIFO_DEPTH[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [BW-1:0] BAUD_ONE  = 1;
    localparam logic [BW-1:0] BAUD_LAST = BAUD_LAST_I[BW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Only the nibble-position bit of the execute counter matters here.
    logic ctr_hi_unused;
    assign ctr_hi_unused = i_utx_ctr[1];

    logic [3:0] lo_q;
    logic       pend_q;
    logic       byte_vld;
    logic [7:0] byte_d;

    assign byte_vld = i_utx_vld & i_utx_ctr[0] & pend_q;
    assign byte_d   = {i_utx_data, lo_q};

    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            lo_q   <= '0;
            pend_q <= 1'b0;
        end else if (i_utx_vld) begin
            if (!i_utx_ctr[0]) begin
                lo_q   <= i_utx_data;
                pend_q <= 1'b1;
            end else begin
                pend_q <= 1'b0;
            end
        end
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          ovf_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign push       = byte_vld & (~fifo_full | pop);

    always_ff @(posedge i_utx_gck) begin
        if (push) begin
            mem_q[wr_ptr_q] <= byte_d;
        end
    end

    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // A drop wins over a simultaneous clear so the event is never lost.
    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            ovf_q <= 1'b0;
        end else if (byte_vld && !push) begin
            ovf_q <= 1'b1;
        end else if (i_utx_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          tx_q;
    logic          tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign o_utx_tx   = tx_q;
    assign o_utx_busy = (state_q != ST_IDLE) || !fifo_empty;
    assign o_utx_ovf  = ovf_q;

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Testbench for idli_uart_tx_m: directed scenarios plus random nibble traffic,
// compared every cycle against a frame-timing model of the transmitter.
module tb_idli_uart_tx_m;

    localparam int DEPTH = 4;
    localparam int BAUD  = 4;
    localparam int FRAME = 10 * BAUD;

    logic       gck = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data = '0;
    logic       vld = 1'b0;
    logic [1:0] ctr = '0;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       busy;
    logic       ovf;

    always #5 gck = ~gck;

    idli_uart_tx_m #(
        .FIFO_DEPTH (DEPTH),
        .BAUD_DIV   (BAUD)
    ) dut (
        .i_utx_gck     (gck),
        .i_utx_rst_n   (rst_n),
        .i_utx_data    (data),
        .i_utx_vld     (vld),
        .i_utx_ctr     (ctr),
        .i_utx_ovf_clr (ovf_clr),
        .o_utx_tx      (tx),
        .o_utx_busy    (busy),
        .o_utx_ovf     (ovf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a byte queue plus the elapsed time inside the current frame.
    logic [7:0] m_q[$];
    bit         m_pend;
    logic [3:0] m_lo;
    bit         m_act;
    int         m_t;
    logic [7:0] m_cur;
    bit         m_ovf;

    function automatic bit m_tx();
        int bi;
        if (!m_act) return 1'b1;
        bi = m_t / BAUD;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return m_cur[bi-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend = 0;
        m_lo   = '0;
        m_act  = 0;
        m_t    = 0;
        m_ovf  = 0;
    endtask

    task automatic model_step();
        bit dropped;
        dropped = 0;
        if (m_act) begin
            if (m_t == FRAME - 1) m_act = 0;
            else m_t++;
        end
        if (!m_act && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_act = 1;
            m_t   = 0;
        end
        if (vld) begin
            if (!ctr[0]) begin
                m_lo   = data;
                m_pend = 1;
            end else begin
                if (m_pend) begin
                    if (m_q.size() < DEPTH) m_q.push_back({data, m_lo});
                    else dropped = 1;
                end
                m_pend = 0;
            end
        end
        if (dropped) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    task automatic cyc(input bit v, input logic [3:0] d, input logic [1:0] c, input bit clr);
        vld = v;
        data = d;
        ctr = c;
        ovf_clr = clr;
        @(posedge gck);
        model_step();
        #1;
        chk("tx", tx, m_tx());
        chk("busy", busy, (m_act || m_q.size() > 0));
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 2'd0, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] frame_bits;
        int         drop_at;
        logic [1:0] rctr;

        model_reset();
        #12;
        chk("init_tx", tx, 1);
        chk("init_busy", busy, 0);
        chk("init_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge gck);
        #1;

        // Single byte 0xA5: sample mid-bit and find when busy drops.
        cyc(1, 4'h5, 2'd0, 0);
        cyc(1, 4'hA, 2'd1, 0);
        frame_bits = '0;
        drop_at = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc(0, 4'h0, 2'd0, 0);
            if ((k % BAUD) == 2 && k < FRAME) frame_bits[k / BAUD] = tx;
            if (drop_at < 0 && !busy) drop_at = k;
        end
        chk("frame_a5", frame_bits, 10'h34A);
        chk("busy_drop", drop_at, FRAME + 1);

        // Full op stream -> 0x21, 0x43 back to back.
        cyc(1, 4'h1, 2'd0, 0);
        cyc(1, 4'h2, 2'd1, 0);
        cyc(1, 4'h3, 2'd2, 0);
        cyc(1, 4'h4, 2'd3, 0);
        idle(2 * FRAME + 5);

        // Six bytes into a 4-deep FIFO: the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            cyc(1, 4'(i), 2'd0, 0);
            cyc(1, 4'(i + 8), 2'd1, 0);
        end
        chk("ovf_after_drop", ovf, 1);
        cyc(1, 4'h7, 2'd0, 0);
        cyc(1, 4'h8, 2'd1, 1);
        chk("ovf_set_prio", ovf, 1);
        cyc(0, 4'h0, 2'd0, 1);
        chk("ovf_cleared", ovf, 0);
        idle(5 * FRAME + 10);
        chk("drained", busy, 0);

        // Orphan high nibble, then 0x0F.
        cyc(1, 4'h9, 2'd1, 0);
        cyc(1, 4'hF, 2'd0, 0);
        cyc(1, 4'h0, 2'd1, 0);
        idle(FRAME + 5);

        // Reset in the middle of data bit 3.
        cyc(1, 4'h3, 2'd0, 0);
        cyc(1, 4'h6, 2'd1, 0);
        idle(18);
        pulse_reset();
        idle(20);
        chk("post_rst_idle", busy, 0);

        // Random traffic with a mostly sequential execute counter.
        rctr = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rctr = 2'($urandom_range(0, 3));
            cyc(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rctr,
                ($urandom_range(0, 39) == 0));
            rctr = rctr + 2'd1;
        end
        idle((DEPTH + 1) * FRAME + 5);
        chk("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
